// File: rtl/mem_wb_if.sv
// MEM->WB stage bundle: EX/MEM slot, memory read return, and the
// registered write-back triple seen by the register file and forwarding.
interface mem_wb_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
);
  localparam int BW = $clog2(XLEN/8);

  logic             in_valid;
  logic             in_is_load;
  logic [2:0]       dm_ctrl;
  logic [BW-1:0]    bias;
  logic             RegWrite_in;
  logic [RF_AW-1:0] rd_in;
  logic [1:0]       WDSel_in;
  logic [XLEN-1:0]  WD_in;
  logic             flush;
  logic             rdata_valid;
  logic [XLEN-1:0]  raw_Data_in;

  logic             stall;
  logic [XLEN-1:0]  MEM_WB_Forward_Data;
  logic             wb_valid;
  logic             RegWrite;
  logic [RF_AW-1:0] rd;
  logic [XLEN-1:0]  WD;
  logic             misalign;
  logic             bus_err;

  // Upstream pipeline / memory side
  modport master (
    output in_valid, in_is_load, dm_ctrl, bias, RegWrite_in, rd_in,
           WDSel_in, WD_in, flush, rdata_valid, raw_Data_in,
    input  stall, MEM_WB_Forward_Data, wb_valid, RegWrite, rd, WD,
           misalign, bus_err
  );

  // The MEM->WB stage itself
  modport slave (
    input  in_valid, in_is_load, dm_ctrl, bias, RegWrite_in, rd_in,
           WDSel_in, WD_in, flush, rdata_valid, raw_Data_in,
    output stall, MEM_WB_Forward_Data, wb_valid, RegWrite, rd, WD,
           misalign, bus_err
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// Registered MEM->WB stage: load lane extraction and extension, variable
// latency read wait with upstream stall, misalign / timeout reporting.
module mem_wb_pipe #(
  parameter int XLEN    = 32,
  parameter int RF_AW   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   rst,
  mem_wb_if.slave bus
);
  localparam int BW = $clog2(XLEN/8);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state, nxt_state;
  logic [CW-1:0]    cnt;

  // controls captured when a load has to wait for its data
  logic [2:0]       lat_ctrl;
  logic [BW-1:0]    lat_bias;
  logic [RF_AW-1:0] lat_rd;
  logic             lat_rw;
  logic [1:0]       lat_sel;
  logic [XLEN-1:0]  lat_wd;

  // registered write-back outputs
  logic             wb_valid_q, rw_q, mis_q, berr_q;
  logic [RF_AW-1:0] rd_q;
  logic [XLEN-1:0]  wd_q;

  // next values for those registers
  logic             stall_c, n_valid, n_rw, n_mis, n_berr;
  logic [RF_AW-1:0] n_rd;
  logic [XLEN-1:0]  n_wd;

  logic             mis_now, accept_wait, cnt_hit;
  logic [2:0]       ex_ctrl;
  logic [BW-1:0]    ex_bias;
  logic [XLEN-1:0]  ld_data;

  // Shift the addressed lane down to bit 0, then extend by access type.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] ctrl,
                                              input logic [BW-1:0] b,
                                              input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] sh, r;
    sh = raw >> {b, 3'b000};
    r  = '0;
    case (ctrl)
      3'd0: r = XLEN'($signed(sh[31:0]));
      3'd1: r = XLEN'($signed(sh[15:0]));
      3'd2: r = XLEN'($signed(sh[7:0]));
      3'd3: r = XLEN'(sh[15:0]);
      3'd4: r = XLEN'(sh[7:0]);
      3'd5: if (XLEN == 64) r = sh;
      3'd6: if (XLEN == 64) r = XLEN'(sh[31:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Offset must be a multiple of access size; unsupported codes never trap.
  function automatic logic misaligned(input logic [2:0] ctrl, input logic [BW-1:0] b);
    logic m;
    m = 1'b0;
    case (ctrl)
      3'd0:       m = |b[1:0];
      3'd1, 3'd3: m = b[0];
      3'd5:       m = (XLEN == 64) && (|b);
      3'd6:       m = (XLEN == 64) && (|b[1:0]);
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

  assign mis_now     = misaligned(bus.dm_ctrl, bus.bias);
  assign accept_wait = bus.in_valid & bus.in_is_load & ~mis_now & ~bus.rdata_valid;
  assign cnt_hit     = (cnt == CW'(TIMEOUT));

  // One extractor: live controls in IDLE, captured controls in WAIT
  assign ex_ctrl = (state == S_WAIT) ? lat_ctrl : bus.dm_ctrl;
  assign ex_bias = (state == S_WAIT) ? lat_bias : bus.bias;
  assign ld_data = extract(ex_ctrl, ex_bias, bus.raw_Data_in);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end

  // Next-state: park in WAIT until data, flush or timeout
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  if (accept_wait) nxt_state = S_WAIT;
      S_WAIT:  if (bus.flush | bus.rdata_valid | cnt_hit) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Output decode: stall and the next write-back register contents
  always_comb begin
    stall_c = 1'b0;
    n_valid = 1'b0;
    n_rw    = 1'b0;
    n_mis   = 1'b0;
    n_berr  = 1'b0;
    n_rd    = rd_q;
    n_wd    = wd_q;
    case (state)
      S_IDLE: begin
        stall_c = accept_wait;
        if (bus.in_valid) begin
          if (!bus.in_is_load) begin
            n_valid = 1'b1;
            n_rw    = bus.RegWrite_in;
            n_rd    = bus.rd_in;
            n_wd    = bus.WD_in;
          end else if (mis_now) begin
            n_valid = 1'b1;
            n_mis   = 1'b1;
          end else if (bus.rdata_valid) begin
            n_valid = 1'b1;
            n_rw    = bus.RegWrite_in;
            n_rd    = bus.rd_in;
            n_wd    = (bus.WDSel_in == 2'b01) ? ld_data : bus.WD_in;
          end
        end
      end
      S_WAIT: begin
        stall_c = ~(bus.rdata_valid | bus.flush | cnt_hit);
        if (bus.flush) begin
          n_valid = 1'b0;
        end else if (bus.rdata_valid) begin
          n_valid = 1'b1;
          n_rw    = lat_rw;
          n_rd    = lat_rd;
          n_wd    = (lat_sel == 2'b01) ? ld_data : lat_wd;
        end else if (cnt_hit) begin
          n_valid = 1'b1;
          n_berr  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Write-back registers and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      cnt        <= '0;
    end else begin
      wb_valid_q <= n_valid;
      rw_q       <= n_rw;
      rd_q       <= n_rd;
      wd_q       <= n_wd;
      mis_q      <= n_mis;
      berr_q     <= n_berr;
      if (state == S_IDLE) cnt <= accept_wait ? CW'(1) : '0;
      else                 cnt <= (nxt_state == S_WAIT) ? cnt + CW'(1) : '0;
    end
  end

  // Capture the waiting load's controls on entry to WAIT
  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept_wait) begin
      lat_ctrl <= bus.dm_ctrl;
      lat_bias <= bus.bias;
      lat_rd   <= bus.rd_in;
      lat_rw   <= bus.RegWrite_in;
      lat_sel  <= bus.WDSel_in;
      lat_wd   <= bus.WD_in;
    end
  end

  assign bus.stall               = stall_c;
  assign bus.wb_valid            = wb_valid_q;
  assign bus.RegWrite            = rw_q;
  assign bus.rd                  = rd_q;
  assign bus.WD                  = wd_q;
  assign bus.MEM_WB_Forward_Data = wd_q;
  assign bus.misalign            = mis_q;
  assign bus.bus_err             = berr_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: one XLEN=32 and one XLEN=64 instance, directed
// cases then random transactions against a transaction-level model.
module tb_mem_wb_pipe;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_if #(.XLEN(32), .RF_AW(5)) if32 ();
  mem_wb_if #(.XLEN(64), .RF_AW(5)) if64 ();

  mem_wb_pipe #(.XLEN(32), .RF_AW(5), .TIMEOUT(TMO)) u32 (.clk(clk), .rst(rst), .bus(if32));
  mem_wb_pipe #(.XLEN(64), .RF_AW(5), .TIMEOUT(TMO)) u64 (.clk(clk), .rst(rst), .bus(if64));

  typedef struct {
    logic        in_valid, in_is_load, RegWrite_in, flush, rdata_valid;
    logic [2:0]  dm_ctrl, bias;
    logic [4:0]  rd_in;
    logic [1:0]  WDSel_in;
    logic [63:0] WD_in, raw;
  } drv_t;

  typedef struct {
    logic        stall, wb_valid, RegWrite, misalign, bus_err;
    logic [4:0]  rd;
    logic [63:0] WD, fwd;
  } obs_t;

  drv_t d [2];
  obs_t o [2];

  assign if32.in_valid    = d[0].in_valid;
  assign if32.in_is_load  = d[0].in_is_load;
  assign if32.dm_ctrl     = d[0].dm_ctrl;
  assign if32.bias        = d[0].bias[1:0];
  assign if32.RegWrite_in = d[0].RegWrite_in;
  assign if32.rd_in       = d[0].rd_in;
  assign if32.WDSel_in    = d[0].WDSel_in;
  assign if32.WD_in       = d[0].WD_in[31:0];
  assign if32.flush       = d[0].flush;
  assign if32.rdata_valid = d[0].rdata_valid;
  assign if32.raw_Data_in = d[0].raw[31:0];

  assign if64.in_valid    = d[1].in_valid;
  assign if64.in_is_load  = d[1].in_is_load;
  assign if64.dm_ctrl     = d[1].dm_ctrl;
  assign if64.bias        = d[1].bias;
  assign if64.RegWrite_in = d[1].RegWrite_in;
  assign if64.rd_in       = d[1].rd_in;
  assign if64.WDSel_in    = d[1].WDSel_in;
  assign if64.WD_in       = d[1].WD_in;
  assign if64.flush       = d[1].flush;
  assign if64.rdata_valid = d[1].rdata_valid;
  assign if64.raw_Data_in = d[1].raw;

  always_comb begin
    o[0].stall = if32.stall;   o[0].wb_valid = if32.wb_valid; o[0].RegWrite = if32.RegWrite;
    o[0].misalign = if32.misalign; o[0].bus_err = if32.bus_err; o[0].rd = if32.rd;
    o[0].WD = {32'h0, if32.WD}; o[0].fwd = {32'h0, if32.MEM_WB_Forward_Data};
    o[1].stall = if64.stall;   o[1].wb_valid = if64.wb_valid; o[1].RegWrite = if64.RegWrite;
    o[1].misalign = if64.misalign; o[1].bus_err = if64.bus_err; o[1].rd = if64.rd;
    o[1].WD = if64.WD; o[1].fwd = if64.MEM_WB_Forward_Data;
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] last_wd [2];
  logic [4:0]  last_rd [2];
  bit          have_last [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, signedness, and whether the code exists at this XLEN
  function automatic void ld_kind(input int xl, input int ctrl,
                                  output int sz, output bit sg, output bit sup);
    sz = 1; sg = 0; sup = 1;
    case (ctrl)
      0: begin sz = 4; sg = 1; end
      1: begin sz = 2; sg = 1; end
      2: begin sz = 1; sg = 1; end
      3: sz = 2;
      4: sz = 1;
      5: begin sz = 8; sup = (xl == 64); end
      6: begin sz = 4; sup = (xl == 64); end
      default: sup = 0;
    endcase
  endfunction

  // Reference load value: take the addressed bytes numerically, extend in 64 bits
  function automatic logic [63:0] ref_ext(input int xl, input int ctrl, input int bias,
                                          input logic [63:0] raw);
    int sz; bit sg, sup;
    logic [63:0] v, m, p;
    ld_kind(xl, ctrl, sz, sg, sup);
    if (!sup) return 64'h0;
    if (xl == 32) raw = raw & 64'hFFFF_FFFF;
    v = raw >> (8 * bias);
    if (sz == 8) return v;
    m = 64'd1 << (8 * sz);
    p = v % m;
    if (sg && p >= (m >> 1)) p = p - m;
    if (xl == 32) p = p & 64'hFFFF_FFFF;
    return p;
  endfunction

  // One instruction through instance s. dly: WAIT cycle on which data shows
  // (0 = present at acceptance). fl: WAIT cycle carrying flush (0 = none).
  task automatic txn(input int s, input bit ld, input int ctrl, input int bias,
                     input logic [63:0] raw, input logic [1:0] wdsel, input bit rw,
                     input logic [4:0] rdv, input logic [63:0] wdin,
                     input int dly, input int fl);
    int xl, sz, endc, kind;
    bit sg, sup, mis;
    logic [63:0] msk, exp_wd;
    xl  = s ? 64 : 32;
    msk = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    ld_kind(xl, ctrl, sz, sg, sup);
    mis = ld && sup && ((bias % sz) != 0);
    exp_wd = (ld && wdsel == 2'b01) ? ref_ext(xl, ctrl, bias, raw) : (wdin & msk);
    // kind: 0 write, 1 misalign, 2 timeout, 3 flush
    if (!ld || mis || dly == 0) begin
      endc = 0; kind = mis ? 1 : 0;
    end else begin
      endc = TMO; kind = 2;
      if (dly <= endc) begin endc = dly; kind = 0; end
      if (fl != 0 && fl <= endc) begin endc = fl; kind = 3; end
    end
    d[s].in_valid = 1; d[s].in_is_load = ld; d[s].dm_ctrl = 3'(ctrl); d[s].bias = 3'(bias);
    d[s].raw = raw & msk; d[s].WDSel_in = wdsel; d[s].RegWrite_in = rw;
    d[s].rd_in = rdv; d[s].WD_in = wdin & msk;
    for (int c = 0; c <= endc; c++) begin
      d[s].rdata_valid = (c >= dly);
      d[s].flush = (c != 0 && c == fl);
      #1;
      chk("stall", 64'(o[s].stall), 64'(c < endc));
      @(posedge clk); #1;
      if (c < endc) begin
        chk("wait_wb_valid", 64'(o[s].wb_valid), 64'd0);
        chk("wait_regwrite", 64'(o[s].RegWrite), 64'd0);
        chk("wait_bus_err", 64'(o[s].bus_err), 64'd0);
      end
    end
    chk("wb_valid", 64'(o[s].wb_valid), 64'(kind != 3));
    chk("regwrite", 64'(o[s].RegWrite), 64'(kind == 0 && rw));
    chk("misalign", 64'(o[s].misalign), 64'(kind == 1));
    chk("bus_err", 64'(o[s].bus_err), 64'(kind == 2));
    if (kind == 0) begin
      chk("wd", o[s].WD, exp_wd);
      chk("fwd", o[s].fwd, exp_wd);
      chk("rd", 64'(o[s].rd), 64'(rdv));
      last_wd[s] = exp_wd; last_rd[s] = rdv; have_last[s] = 1;
    end else begin
      have_last[s] = 0;
    end
    d[s].in_valid = 0; d[s].flush = 0; d[s].rdata_valid = 0;
  endtask

  // Empty slot: nothing written, pulses gone, WD/rd held
  task automatic idle(input int s);
    d[s].in_valid = 0; d[s].flush = 0;
    d[s].rdata_valid = 1'($urandom_range(0, 1));
    #1;
    chk("idle_stall", 64'(o[s].stall), 64'd0);
    @(posedge clk); #1;
    chk("idle_wb_valid", 64'(o[s].wb_valid), 64'd0);
    chk("idle_regwrite", 64'(o[s].RegWrite), 64'd0);
    chk("idle_misalign", 64'(o[s].misalign), 64'd0);
    chk("idle_bus_err", 64'(o[s].bus_err), 64'd0);
    if (have_last[s]) begin
      chk("idle_wd_hold", o[s].WD, last_wd[s]);
      chk("idle_rd_hold", 64'(o[s].rd), 64'(last_rd[s]));
    end
  endtask

  task automatic chk_zero(input int s);
    chk("rst_wb_valid", 64'(o[s].wb_valid), 64'd0);
    chk("rst_regwrite", 64'(o[s].RegWrite), 64'd0);
    chk("rst_rd", 64'(o[s].rd), 64'd0);
    chk("rst_wd", o[s].WD, 64'd0);
    chk("rst_misalign", 64'(o[s].misalign), 64'd0);
    chk("rst_bus_err", 64'(o[s].bus_err), 64'd0);
    last_wd[s] = 0; last_rd[s] = 0; have_last[s] = 1;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      d[s] = '{default: '0};
      have_last[s] = 0;
    end
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0); chk_zero(1);
    chk("rst_stall", 64'(o[0].stall), 64'd0);
    rst = 0;

    // XLEN=32 directed
    txn(0, 1, 2, 3, 64'h80FF1234, 2'b01, 1, 5'd3, 64'h0, 0, 0);          // lb  -> FFFFFF80
    txn(0, 1, 4, 3, 64'h80FF1234, 2'b01, 1, 5'd3, 64'h0, 0, 0);          // lbu -> 00000080
    txn(0, 1, 1, 1, 64'h11223344, 2'b01, 1, 5'd4, 64'h0, 0, 0);          // lh bias 1: misalign
    idle(0);
    txn(0, 1, 3, 2, 64'h9ABC0000, 2'b01, 1, 5'd6, 64'h0, 0, 0);          // lhu -> 9ABC
    idle(0);
    txn(0, 1, 0, 0, 64'h12345678, 2'b01, 1, 5'd7, 64'h0, 3, 0);          // lw, data 3 late
    idle(0);
    txn(0, 1, 0, 0, 64'hDEADBEEF, 2'b01, 1, 5'd8, 64'h0, 1000, 0);       // timeout
    idle(0);
    txn(0, 1, 0, 0, 64'hCAFEF00D, 2'b01, 1, 5'd9, 64'h0, 2, 2);          // flush wins over data
    txn(0, 0, 0, 0, 64'h0, 2'b00, 1, 5'd10, 64'h5, 0, 0);                // ALU op right after
    txn(0, 0, 0, 0, 64'h0, 2'b00, 1, 5'd0, 64'h77, 0, 0);                // rd = x0
    txn(0, 1, 0, 0, 64'h12345678, 2'b10, 1, 5'd11, 64'hABCD, 2, 0);      // load, WD_in selected
    txn(0, 1, 5, 0, 64'h12345678, 2'b01, 1, 5'd12, 64'h0, 0, 0);         // dword at 32 -> 0
    idle(0);

    // XLEN=64 directed
    txn(1, 1, 5, 0, 64'h8000_0000_0000_0001, 2'b01, 1, 5'd1, 64'h0, 0, 0);  // ld
    txn(1, 1, 0, 4, 64'h8000_0000_1234_5678, 2'b01, 1, 5'd2, 64'h0, 0, 0);  // lw  -> FFFFFFFF80000000
    txn(1, 1, 6, 4, 64'h8000_0000_1234_5678, 2'b01, 1, 5'd3, 64'h0, 0, 0);  // lwu -> 0000000080000000
    txn(1, 1, 5, 4, 64'h8000_0000_1234_5678, 2'b01, 1, 5'd4, 64'h0, 0, 0);  // ld bias 4: misalign
    idle(1);

    // Reset while the 64-bit instance is waiting
    d[1].in_valid = 1; d[1].in_is_load = 1; d[1].dm_ctrl = 3'd5; d[1].bias = 3'd0;
    d[1].rdata_valid = 0; d[1].RegWrite_in = 1; d[1].rd_in = 5'd9; d[1].WDSel_in = 2'b01;
    d[1].raw = 64'h1; d[1].WD_in = 64'h2;
    #1; chk("pre_rst_stall", 64'(o[1].stall), 64'd1);
    repeat (2) @(posedge clk);
    #1; chk("wait_stall", 64'(o[1].stall), 64'd1);
    rst = 1;
    d[1].rdata_valid = 1;
    @(posedge clk); #1;
    chk_zero(1); chk_zero(0);
    rst = 0;
    d[1].in_valid = 0; d[1].rdata_valid = 0;
    #1; chk("post_rst_stall", 64'(o[1].stall), 64'd0);
    idle(1);

    // Random transactions on both widths
    for (int n = 0; n < 150; n++) begin
      for (int s = 0; s < 2; s++) begin
        bit ld, rw;
        int ctrl, bias, dly, fl;
        logic [1:0] sel;
        ld   = ($urandom_range(0, 2) != 0);
        ctrl = $urandom_range(0, 7);
        bias = $urandom_range(0, s ? 7 : 3);
        sel  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
        rw   = 1'($urandom_range(0, 1));
        dly  = $urandom_range(0, TMO + 2);
        fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO) : 0;
        txn(s, ld, ctrl, bias, {$urandom, $urandom}, sel, rw, 5'($urandom),
            {$urandom, $urandom}, dly, fl);
        if ($urandom_range(0, 1) == 1) idle(s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
